// File: rtl/audio_clk_gen.sv
// audio_clk_gen: multi-channel phase-accumulator clock generator.
// Each channel's clock is the registered MSB of its accumulator. Increment
// and enable updates pass through a single pending slot and are committed
// only on a channel wrap, so the output never produces a runt pulse. A global
// sync zeroes every accumulator, and a lock flag reports a quiet period.
module audio_clk_gen #(
  parameter int unsigned              NUM_CH      = 2,
  parameter int unsigned              ACC_W       = 32,
  parameter int unsigned              LOCK_CYCLES = 16,
  parameter logic [NUM_CH*ACC_W-1:0]  INC_INIT    = {NUM_CH{32'h5555_5555}},
  parameter logic [NUM_CH-1:0]        EN_INIT     = {NUM_CH{1'b1}},
  localparam int unsigned             CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              cfg_en,
  input  logic              sync_req,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] outclk_stb,
  output logic              locked
);

  localparam int unsigned      CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic {
    S_UNLOCKED = 1'b0,
    S_LOCKED   = 1'b1
  } lock_state_t;

  // Channel state
  logic [ACC_W-1:0]  r_acc [NUM_CH];
  logic [ACC_W-1:0]  r_inc [NUM_CH];
  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] r_outclk;
  logic [NUM_CH-1:0] r_stb;

  // Pending configuration slot
  logic              r_pend_valid;
  logic [CH_W-1:0]   r_pend_ch;
  logic [ACC_W-1:0]  r_pend_inc;
  logic              r_pend_en;
  logic              r_ready;

  // Lock FSM
  lock_state_t       r_state;
  lock_state_t       w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_locked;

  // Combinational helpers
  logic [ACC_W:0]    w_sum     [NUM_CH];
  logic [ACC_W-1:0]  w_acc_nxt [NUM_CH];
  logic [NUM_CH-1:0] w_wrap;
  logic [NUM_CH-1:0] w_msb_nxt;
  logic [NUM_CH-1:0] w_sel;
  logic              w_xfer;
  logic              w_cfg_ch_ok;
  logic              w_pend_ch_ok;
  logic              w_pend_due;
  logic              w_apply;
  logic              w_drop;
  logic              w_pend_nxt;
  logic              w_disturb;

  // Per-channel add with carry-out; a carry only counts as a wrap when enabled.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_sum[i]  = {1'b0, r_acc[i]} + {1'b0, r_inc[i]};
      w_wrap[i] = r_en[i] & w_sum[i][ACC_W];
      if (sync_req) begin
        w_acc_nxt[i] = '0;
      end else if (r_en[i]) begin
        w_acc_nxt[i] = w_sum[i][ACC_W-1:0];
      end else begin
        w_acc_nxt[i] = r_acc[i];
      end
      w_msb_nxt[i] = w_acc_nxt[i][ACC_W-1];
    end
  end

  // One-hot decode of the pending target; all-zero means out-of-range channel.
  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_sel[i] = (r_pend_ch == CH_W'(i));
    end
  end

  assign w_xfer       = cfg_valid & r_ready;
  assign w_cfg_ch_ok  = (32'(cfg_ch) < NUM_CH);
  assign w_pend_ch_ok = |w_sel;
  // A disable, or a target already stopped, cannot wait for a wrap, so it
  // commits on the following cycle; sync forces any pending update through.
  assign w_pend_due   = sync_req | ~r_pend_en | (|(w_sel & (w_wrap | ~r_en)));
  assign w_apply      = r_pend_valid & w_pend_ch_ok & w_pend_due;
  assign w_drop       = r_pend_valid & ~w_pend_ch_ok;
  assign w_pend_nxt   = w_xfer | (r_pend_valid & ~w_apply & ~w_drop);
  assign w_disturb    = sync_req | (w_xfer & w_cfg_ch_ok) | (r_pend_valid & w_pend_ch_ok);

  // Accumulators, increments, enables and registered clock/strobe outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_acc[i] <= '0;
        r_inc[i] <= INC_INIT[i*ACC_W +: ACC_W];
      end
      r_en     <= EN_INIT;
      r_outclk <= '0;
      r_stb    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_acc[i] <= w_acc_nxt[i];
        if (w_apply && w_sel[i]) begin
          r_inc[i] <= r_pend_inc;
          r_en[i]  <= r_pend_en;
        end
      end
      r_outclk <= w_msb_nxt;
      r_stb    <= w_msb_nxt & ~r_outclk;
    end
  end

  // Pending slot and ready flag; ready is simply "slot empty next cycle".
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_pend_valid <= 1'b0;
      r_pend_ch    <= '0;
      r_pend_inc   <= '0;
      r_pend_en    <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_pend_valid <= w_pend_nxt;
      r_ready      <= ~w_pend_nxt;
      if (w_xfer) begin
        r_pend_ch  <= cfg_ch;
        r_pend_inc <= cfg_inc;
        r_pend_en  <= cfg_en;
      end
    end
  end

  // Lock FSM state and quiet-cycle counter register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state <= S_UNLOCKED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Lock FSM next-state: count quiet cycles, drop lock on any valid reconfig or sync.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_UNLOCKED: begin
        if (w_disturb) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_LOCKED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_LOCKED: begin
        if (sync_req || (w_xfer && w_cfg_ch_ok)) begin
          w_state_nxt = S_UNLOCKED;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_UNLOCKED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Lock FSM output decode.
  always_comb begin
    w_locked = (r_state == S_LOCKED);
  end

  assign cfg_ready  = r_ready;
  assign outclk     = r_outclk;
  assign outclk_stb = r_stb;
  assign locked     = w_locked;

endmodule

// File: tb/tb_audio_clk_gen.sv
// Testbench for audio_clk_gen: directed scenarios plus randomized traffic,
// checked every cycle against an integer-arithmetic model of the generator.
module tb_audio_clk_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [0:0] cfg_ch;
  logic [7:0] cfg_inc;
  logic       cfg_en;
  logic       sync_req;
  logic [1:0] outclk;
  logic [1:0] outclk_stb;
  logic       locked;

  // Second instance with a 2-bit channel field so an out-of-range index exists.
  logic       cfg3_valid;
  logic       ready3;
  logic [1:0] cfg3_ch;
  logic [7:0] cfg3_inc;
  logic       cfg3_en;
  logic       sync3 = 1'b0;
  logic [2:0] outclk3;
  logic [2:0] outclk3_stb;
  logic       locked3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  audio_clk_gen #(
    .NUM_CH(2), .ACC_W(8), .LOCK_CYCLES(4),
    .INC_INIT(16'h2040), .EN_INIT(2'b11)
  ) u_dut (
    .refclk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_en(cfg_en), .sync_req(sync_req),
    .outclk(outclk), .outclk_stb(outclk_stb), .locked(locked)
  );

  audio_clk_gen #(
    .NUM_CH(3), .ACC_W(8), .LOCK_CYCLES(4),
    .INC_INIT(24'h102040), .EN_INIT(3'b111)
  ) u_dut3 (
    .refclk(clk), .rst(rst), .cfg_valid(cfg3_valid), .cfg_ready(ready3),
    .cfg_ch(cfg3_ch), .cfg_inc(cfg3_inc), .cfg_en(cfg3_en), .sync_req(sync3),
    .outclk(outclk3), .outclk_stb(outclk3_stb), .locked(locked3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (main instance) ----------------
  int  m_acc [2];
  int  m_inc [2];
  bit  m_en  [2];
  bit  m_oc  [2];
  bit  m_stb [2];
  bit  m_wrap[2];
  bit  m_pv, m_pen, m_ready, m_started;
  int  m_pch, m_pinc, m_quiet;
  bit  mx, m_apply, m_drop, m_dist, m_new;

  always @(posedge clk) begin
    m_started = 1'b1;
    if (rst) begin
      m_acc[0] = 0;     m_acc[1] = 0;
      m_inc[0] = 'h40;  m_inc[1] = 'h20;
      m_en[0]  = 1'b1;  m_en[1]  = 1'b1;
      m_oc[0]  = 1'b0;  m_oc[1]  = 1'b0;
      m_stb[0] = 1'b0;  m_stb[1] = 1'b0;
      m_pv = 1'b0; m_ready = 1'b0; m_quiet = 0;
    end else begin
      mx = cfg_valid && m_ready;
      for (int i = 0; i < 2; i++) m_wrap[i] = m_en[i] && (m_acc[i] + m_inc[i] >= 256);
      m_apply = 1'b0;
      m_drop  = 1'b0;
      if (m_pv) begin
        if (m_pch >= 2) m_drop = 1'b1;
        else if (sync_req || !m_pen || !m_en[m_pch] || m_wrap[m_pch]) m_apply = 1'b1;
      end
      m_dist  = sync_req || (mx && int'(cfg_ch) < 2) || (m_pv && m_pch < 2);
      m_quiet = m_dist ? 0 : ((m_quiet < 1000) ? m_quiet + 1 : m_quiet);
      for (int i = 0; i < 2; i++) begin
        if (sync_req) m_acc[i] = 0;
        else if (m_en[i]) m_acc[i] = (m_acc[i] + m_inc[i]) % 256;
      end
      if (m_apply) begin
        m_inc[m_pch] = m_pinc;
        m_en[m_pch]  = m_pen;
      end
      if (m_apply || m_drop) m_pv = 1'b0;
      if (mx) begin
        m_pv = 1'b1; m_pch = int'(cfg_ch); m_pinc = int'(cfg_inc); m_pen = cfg_en;
      end
      m_ready = !m_pv;
      for (int i = 0; i < 2; i++) begin
        m_new    = (m_acc[i] >= 128);
        m_stb[i] = m_new && !m_oc[i];
        m_oc[i]  = m_new;
      end
    end
  end

  // ---------------- closed-form model (second instance) ----------------
  int inc3[3] = '{'h40, 'h20, 'h10};
  int n3;
  bit m3_pv, m3_ready;

  function automatic bit oc3(input int n, input int i);
    return ((n * inc3[i]) % 256) >= 128;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      n3 = 0; m3_pv = 1'b0; m3_ready = 1'b0;
    end else begin
      n3++;
      m3_pv    = cfg3_valid && m3_ready;
      m3_ready = !m3_pv;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_started) begin
      chk("outclk",     32'(outclk),     32'({m_oc[1], m_oc[0]}));
      chk("outclk_stb", 32'(outclk_stb), 32'({m_stb[1], m_stb[0]}));
      chk("locked",     32'(locked),     32'(m_quiet >= 4));
      chk("cfg_ready",  32'(cfg_ready),  32'(m_ready));
      for (int i = 0; i < 3; i++) begin
        chk("u3_outclk", 32'(outclk3[i]),     32'(oc3(n3, i)));
        chk("u3_stb",    32'(outclk3_stb[i]), 32'((n3 > 0) && oc3(n3, i) && !oc3(n3 - 1, i)));
      end
      chk("u3_locked", 32'(locked3), 32'(n3 >= 4));
      chk("u3_ready",  32'(ready3),  32'(m3_ready));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm, input int bound);
    int c = 0;
    while (cfg_ready !== 1'b1 && c < bound) begin
      tick();
      c++;
    end
    chk(nm, 32'(cfg_ready), 32'd1);
  endtask

  task automatic do_cfg(input int ch, input int inc, input bit en);
    cfg_valid = 1'b1;
    cfg_ch    = 1'(ch);
    cfg_inc   = 8'(inc);
    cfg_en    = en;
    wait_ready("cfg_slot_timeout", 200);
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int e_oc0[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    int e_oc1[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    int e_lk [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
    int e_st0[8] = '{0, 1, 0, 0, 0, 1, 0, 0};
    int e_st1[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    int s0_4 [4] = '{0, 1, 0, 0};
    int s1_4 [4] = '{0, 0, 0, 1};
    int cnt, cnt1;
    bit oc_hold;

    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_en = 1'b0; sync_req = 1'b0;
    cfg3_valid = 1'b0; cfg3_ch = '0; cfg3_inc = '0; cfg3_en = 1'b0;
    repeat (3) tick();
    chk("rst_outclk", 32'(outclk), 32'd0);
    chk("rst_stb",    32'(outclk_stb), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_ready",  32'(cfg_ready), 32'd0);

    // T1: periods 4 / 8 and lock on the 4th cycle after release
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick();
      chk("t1_oc0", 32'(outclk[0]), 32'(e_oc0[n]));
      chk("t1_oc1", 32'(outclk[1]), 32'(e_oc1[n]));
      chk("t1_stb0", 32'(outclk_stb[0]), 32'(e_st0[n]));
      chk("t1_stb1", 32'(outclk_stb[1]), 32'(e_st1[n]));
      chk("t1_locked", 32'(locked), 32'(e_lk[n]));
      chk("t1_ready", 32'(cfg_ready), 32'd1);
    end

    // T2: mid-period change of ch0 to inc 0x10, committed at the next wrap
    repeat (2) tick();
    do_cfg(0, 'h10, 1'b1);
    chk("t2_unlock", 32'(locked), 32'd0);
    chk("t2_ready_low", 32'(cfg_ready), 32'd0);
    wait_ready("t2_apply_timeout", 64);
    cnt = 0;
    while (outclk_stb[0] !== 1'b1 && cnt < 64) begin tick(); cnt++; end
    cnt = 0;
    do begin tick(); cnt++; end while (outclk_stb[0] !== 1'b1 && cnt < 64);
    chk("t2_period16", 32'(cnt), 32'd16);

    // T3: disable ch1 commits next cycle, output freezes, then re-enable
    do_cfg(1, 'h20, 1'b0);
    tick();
    chk("t3_apply_next", 32'(cfg_ready), 32'd1);
    oc_hold = outclk[1];
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (outclk_stb[1]) cnt++;
    end
    chk("t3_frozen_level", 32'(outclk[1]), 32'(oc_hold));
    chk("t3_no_strobes", 32'(cnt), 32'd0);
    do_cfg(1, 'h20, 1'b1);
    tick();
    chk("t3_reenable_next", 32'(cfg_ready), 32'd1);

    // T4: restore ch0, free-run, then sync
    do_cfg(0, 'h40, 1'b1);
    wait_ready("t4_apply_timeout", 64);
    repeat (13) tick();
    sync_req = 1'b1;
    tick();
    sync_req = 1'b0;
    chk("t4_outclk_zero", 32'(outclk), 32'd0);
    chk("t4_unlock", 32'(locked), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_stb0", 32'(outclk_stb[0]), 32'(s0_4[k]));
      chk("t4_stb1", 32'(outclk_stb[1]), 32'(s1_4[k]));
    end

    // T5a: transfer and sync on the same edge; slot survives, applies at ch1 wrap
    chk("t5_ready_pre", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_inc = 8'h40; cfg_en = 1'b1; sync_req = 1'b1;
    tick();
    cfg_valid = 1'b0; sync_req = 1'b0;
    chk("t5_pending", 32'(cfg_ready), 32'd0);
    chk("t5_sync_zero", 32'(outclk), 32'd0);
    cnt = 0;
    while (cfg_ready !== 1'b1 && cnt < 50) begin tick(); cnt++; end
    chk("t5_apply_at_wrap", 32'(cnt), 32'd8);

    // T5b: reset while a config is pending restores the initial increments
    sync_req = 1'b1;
    tick();
    sync_req = 1'b0;
    do_cfg(1, 'h08, 1'b1);
    rst = 1'b1;
    repeat (2) tick();
    chk("t5_rst_ready", 32'(cfg_ready), 32'd0);
    chk("t5_rst_outclk", 32'(outclk), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_init_stb0", 32'(outclk_stb[0]), 32'(s0_4[k]));
      chk("t5_init_stb1", 32'(outclk_stb[1]), 32'(s1_4[k]));
    end

    // T5c: out-of-range channel is accepted then dropped, lock untouched
    chk("t5_u3_locked_pre", 32'(locked3), 32'd1);
    chk("t5_u3_ready_pre", 32'(ready3), 32'd1);
    cfg3_valid = 1'b1; cfg3_ch = 2'd3; cfg3_inc = 8'h01; cfg3_en = 1'b0;
    tick();
    cfg3_valid = 1'b0;
    chk("t5_u3_ready_drop", 32'(ready3), 32'd0);
    chk("t5_u3_locked_mid", 32'(locked3), 32'd1);
    tick();
    chk("t5_u3_ready_back", 32'(ready3), 32'd1);
    chk("t5_u3_locked_post", 32'(locked3), 32'd1);

    // T6: zero increment holds ch0 level, ch1 keeps period 8
    do_cfg(0, 0, 1'b1);
    wait_ready("t6_apply_timeout", 50);
    oc_hold = outclk[0];
    cnt  = 0;
    cnt1 = 0;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (outclk_stb[0]) cnt++;
      if (outclk_stb[1]) cnt1++;
      chk("t6_oc0_const", 32'(outclk[0]), 32'(oc_hold));
    end
    chk("t6_no_stb0", 32'(cnt), 32'd0);
    chk("t6_stb1_count", 32'(cnt1), 32'd8);

    // Randomized traffic: configs, syncs and occasional resets
    for (int c = 0; c < 3000; c++) begin
      bit took;
      took = cfg_valid && cfg_ready && !rst;
      tick();
      if (took) cfg_valid = 1'b0;
      sync_req = ($urandom_range(24) == 0);
      rst      = ($urandom_range(399) == 0);
      if (!cfg_valid && $urandom_range(5) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch    = 1'($urandom_range(1));
        cfg_inc   = 8'($urandom);
        cfg_en    = ($urandom_range(3) != 0);
      end
    end
    cfg_valid = 1'b0; sync_req = 1'b0; rst = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
